db_scan_ctrl: RTL and testbench
===============================

# db_scan_ctrl

Multi-channel debounce controller that shares one sample-tick divider and one evaluation datapath across N mechanical switch inputs. It services the channels in a fixed round-robin slot schedule. Per channel it keeps a debounced level and an agreement counter, and it emits one-cycle press/release strobes. It sits between the raw board switch pins and the user logic, replacing one free-running debouncer per button.

## Interface
- `N`, 4: number of switch channels (1..16).
- `TICK_DIV`, 8: clock cycles per sample window. Must satisfy `TICK_DIV >= N`.
- `STABLE`, 3: consecutive disagreeing samples required to change the debounced level (>= 1).
- `clk` input 1: single system clock, rising-edge.
- `reset` input 1: asynchronous, active-low. Clears all state while low.
- `sw` input N: raw asynchronous switch levels.
- `db` output N: debounced levels.
- `rise` output N: one-cycle strobe when `db[i]` goes 0->1.
- `fall` output N: one-cycle strobe when `db[i]` goes 1->0.
- `slot` output clog2(TICK_DIV): current schedule position, for debug and verification.

## Operation
- Synchronizer: each `sw[i]` passes through a 2-flop synchronizer to give `s[i]`. These flops reset to 0.
- Divider: `slot` counts 0..TICK_DIV-1 and wraps to 0. It increments every cycle.
- Scheduler: in the cycle where `slot == i` and `i < N`, channel i is serviced. Slots N..TICK_DIV-1 are idle. Exactly one channel is evaluated per cycle, and each channel is evaluated exactly once per window.
- Channel state: `db[i]` and `cnt[i]`, where `cnt` has width clog2(STABLE+1).
- Service rule for channel i:
  - `s[i] == db[i]`: `cnt[i] <= 0`.
  - `s[i] != db[i]` and `cnt[i] < STABLE-1`: `cnt[i] <= cnt[i]+1`.
  - `s[i] != db[i]` and `cnt[i] == STABLE-1`: `db[i] <= ~db[i]`, `cnt[i] <= 0`, and the matching strobe (`rise` or `fall`) asserts on the next cycle.
- Unserviced channels hold `db` and `cnt`.
- Only channel i's datapath inputs are muxed into the shared comparator/incrementer in its slot.
- Equivalent per-channel FSM, where n = cnt:
  - LOW(n=0) -> LOW_PEND(n) on a high sample.
  - LOW_PEND(n) -> LOW on a low sample.
  - LOW_PEND(STABLE-1) -> HIGH on a high sample.
  - HIGH/HIGH_PEND are symmetric.

## Timing
- Reset values: `db=0`, `rise=0`, `fall=0`, `cnt=0`, `slot=0`, synchronizers 0.
- Release from reset is taken on the first rising edge with `reset` high. That edge moves `slot` 0->1, and channel 0 was not serviced during reset.
- Strobes are registered: `rise[i]` or `fall[i]` is high for exactly the one cycle after the edge on which `db[i]` toggles. The strobe and the new `db[i]` value are visible in the same cycle.
- Latency: from a stable `sw[i]` change to the `db[i]` toggle is 2 synchronizer cycles plus the wait to the next `slot==i`, plus (STABLE-1)*TICK_DIV cycles.
  - Worst case is 2 + TICK_DIV + (STABLE-1)*TICK_DIV cycles.
  - With defaults, the range is 18..26 cycles.
- Filtering: a pulse seen by fewer than STABLE consecutive samples of its channel never toggles `db`. Any agreeing sample restarts the count.
- Simultaneous changes on several channels toggle in their own slots. The strobes are staggered by one cycle per channel index, and there is never more than one strobe bit set per cycle.
- `STABLE == 1`: toggle on the first disagreeing sample.
- Reset asserted mid-count: all counts and levels clear immediately, including any strobe in flight.

## Structure
- Package `db_pkg`: default parameter constants, and a `clog2` helper function if the tool flow lacks `$clog2`.
- Top level `db_scan_ctrl`: synchronizers, divider, slot decode, per-channel register arrays, shared compare/increment, strobe registers.
- One natural sub-module: `db_sync2`, the 2-flop synchronizer with async active-low reset, instantiated N times.

## Test plan
1. Reset held for 3 cycles, then released with `sw=0`: `db`, `rise` and `fall` stay 0 for 100 cycles, and `slot` cycles 0..7.
2. `sw[0]` goes 0->1 and is held: `db[0]` goes high 18..26 cycles later. `rise[0]` is high for exactly 1 cycle in the cycle `db[0]` first reads 1, and no other outputs change.
3. Glitch: `sw[1]` is high for 10 cycles, then low (covering at most 2 channel-1 samples): `db[1]` stays 0 and there is no strobe.
4. Bounce: `sw[2]` follows 1 for 3 cycles, 0 for 4, 1 for 2, 0 for 2, then 1 held. `db[2]` rises exactly once, within 26 cycles after the final transition, and `rise[2]` pulses once.
5. All four `sw` bits go 0->1 on the same cycle: `rise[0]..rise[3]` pulse in 4 consecutive cycles in index order. Dropping all four bits later gives `fall` pulses in the same pattern.
6. `reset` is pulsed low while `cnt[3]` is 2 and `sw[3]=1`: after release, `db[3]` needs a full 18..26 cycles to rise. `db[3]` does not rise early.

Source files
------------

// File: rtl/db_pkg.sv
// -----------------------------------------------------------------------------
// db_pkg
// Shared constants and helpers for the scanned debounce controller.
//   DEF_N        : default number of switch channels
//   DEF_TICK_DIV : default clock cycles per sample window
//   DEF_STABLE   : default consecutive disagreeing samples needed to toggle
//   clog2()      : ceil(log2(v)), for flows without $clog2
//   width_of()   : clog2() clamped to at least 1 bit, for sizing vectors
// -----------------------------------------------------------------------------
package db_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_TICK_DIV = 8;
    localparam int DEF_STABLE   = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A zero-width vector is illegal, so a 1-value range still gets one bit.
    function automatic int width_of(input int v);
        int r;
        r = clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/db_sync2.sv
// -----------------------------------------------------------------------------
// db_sync2
// Two-flop synchronizer for one raw switch level.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low; both flops clear to 0
//   i_async : raw asynchronous input
//   o_sync  : synchronized level, two clock edges behind i_async
// -----------------------------------------------------------------------------
module db_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/db_scan_ctrl.sv
// -----------------------------------------------------------------------------
// db_scan_ctrl
// Multi-channel switch debouncer. One slot counter divides time into windows of
// TICK_DIV cycles; in slot i (i < N) channel i is evaluated by a single shared
// compare/increment datapath. Slots N..TICK_DIV-1 are idle. A channel's
// debounced level flips after STABLE consecutive samples that disagree with it;
// any agreeing sample restarts the count.
//
// Parameters
//   N        : number of channels (1..16)
//   TICK_DIV : cycles per sample window, must be >= N
//   STABLE   : consecutive disagreeing samples required to toggle (>= 1)
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low; clears every register while low
//   sw    : raw switch levels
//   db    : debounced levels
//   rise  : one-cycle strobe, visible together with db[i] going 0->1
//   fall  : one-cycle strobe, visible together with db[i] going 1->0
//   slot  : current schedule position (doubles as the scheduler state)
//
// Each channel behaves as a small FSM {LOW, LOW_PEND(n), HIGH, HIGH_PEND(n)}
// encoded as (db[i], cnt[i]); cnt == 0 is the settled state. The FSM is split
// into a state register, a next-state block and an output block.
// -----------------------------------------------------------------------------
module db_scan_ctrl
    import db_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int STABLE   = DEF_STABLE,
    localparam int SLOT_W  = width_of(TICK_DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      sw,
    output logic [N-1:0]      db,
    output logic [N-1:0]      rise,
    output logic [N-1:0]      fall,
    output logic [SLOT_W-1:0] slot
);

    localparam int                 CNT_W     = width_of(STABLE + 1);
    localparam logic [CNT_W-1:0]   CNT_LIM   = CNT_W'(STABLE - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(TICK_DIV - 1);

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic [N-1:0] w_s;

    for (genvar gi = 0; gi < N; gi++) begin : g_sync
        db_sync2 u_sync (
            .clk     (clk),
            .reset   (reset),
            .i_async (sw[gi]),
            .o_sync  (w_s[gi])
        );
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] r_slot;
    logic [N-1:0]      r_db;
    logic [CNT_W-1:0]  r_cnt [N];
    logic [N-1:0]      r_rise;
    logic [N-1:0]      r_fall;

    logic [SLOT_W-1:0] w_slot_nxt;
    logic [N-1:0]      w_db_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt [N];
    logic [N-1:0]      w_rise_nxt;
    logic [N-1:0]      w_fall_nxt;

    // ------------------------------------------------------------------
    // Slot decode and operand mux: only the serviced channel's sample,
    // level and count reach the shared datapath.
    // ------------------------------------------------------------------
    logic             w_active;
    logic             w_sel_s;
    logic             w_sel_db;
    logic [CNT_W-1:0] w_sel_cnt;

    always_comb begin
        w_active  = 1'b0;
        w_sel_s   = 1'b0;
        w_sel_db  = 1'b0;
        w_sel_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_active  = 1'b1;
                w_sel_s   = w_s[i];
                w_sel_db  = r_db[i];
                w_sel_cnt = r_cnt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared compare / increment
    // ------------------------------------------------------------------
    logic             w_agree;
    logic             w_at_lim;
    logic             w_toggle;
    logic [CNT_W-1:0] w_cnt_upd;

    assign w_agree   = (w_sel_s == w_sel_db);
    assign w_at_lim  = (w_sel_cnt == CNT_LIM);
    assign w_toggle  = w_active && !w_agree && w_at_lim;
    // The count restarts both on agreement and on the toggle itself, since
    // after a toggle the new level agrees with the sample that caused it.
    assign w_cnt_upd = (w_agree || w_at_lim) ? '0 : (w_sel_cnt + CNT_W'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot <= '0;
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_slot <= w_slot_nxt;
            r_db   <= w_db_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Unserviced channels hold; strobes default low so
    // they last exactly one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot_nxt = (r_slot == SLOT_LAST) ? '0 : (r_slot + SLOT_W'(1));
        w_db_nxt   = r_db;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        for (int i = 0; i < N; i++) begin
            if (w_active && (r_slot == SLOT_W'(i))) begin
                w_cnt_nxt[i] = w_cnt_upd;
                if (w_toggle) begin
                    w_db_nxt[i]   = ~r_db[i];
                    w_rise_nxt[i] = ~r_db[i];
                    w_fall_nxt[i] = r_db[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        db   = r_db;
        rise = r_rise;
        fall = r_fall;
        slot = r_slot;
    end

endmodule

// File: tb/tb_db_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_db_scan_ctrl
// Directed scenarios plus a random phase, all compared cycle by cycle against
// a sample-history model: a channel flips when its last STABLE samples all
// differ from its current debounced level.
// -----------------------------------------------------------------------------
module tb_db_scan_ctrl;
  import db_pkg::*;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int ST = 3;
  localparam int SW = 3;
  localparam int EW = SW + 3 * N;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  sw = '0;
  logic [N-1:0]  db;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [SW-1:0] slot;

  always #5 clk = ~clk;

  db_scan_ctrl #(.N(N), .TICK_DIV(TD), .STABLE(ST)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .db    (db),
    .rise  (rise),
    .fall  (fall),
    .slot  (slot)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  int rise_cnt[N];
  int fall_cnt[N];
  int rise_cyc[N];
  int fall_cyc[N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_slot;
  logic [N-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
  logic         m_hist [N][ST];   // [ch][0] is the newest sample
  int           m_nvalid [N];

  function automatic void model_clear();
    m_slot = 0;
    m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < N; c++) begin
      m_nvalid[c] = 0;
      for (int k = 0; k < ST; k++) m_hist[c][k] = 1'b0;
    end
  endfunction

  // Number of most recent samples in a row that differ from the level.
  function automatic int run_len(input int ch);
    int r;
    r = 0;
    for (int k = 0; k < ST; k++) begin
      if (k >= m_nvalid[ch]) break;
      if (m_hist[ch][k] == m_db[ch]) break;
      r++;
    end
    return r;
  endfunction

  function automatic void model_edge();
    int ch;
    m_rise = '0;
    m_fall = '0;
    if (m_slot < N) begin
      ch = m_slot;
      for (int k = ST - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
      m_hist[ch][0] = m_s2[ch];
      if (m_nvalid[ch] < ST) m_nvalid[ch]++;
      if (run_len(ch) == ST) begin
        if (m_db[ch]) m_fall[ch] = 1'b1;
        else          m_rise[ch] = 1'b1;
        m_db[ch] = ~m_db[ch];
      end
    end
    m_s2 = m_s1;
    m_s1 = sw;
    m_slot = (m_slot + 1) % TD;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clk);
    if (reset) model_edge();
    exp_q.push_back({SW'(m_slot), m_db, m_rise, m_fall});
    @(negedge clk);
    cyc++;
    e = exp_q.pop_front();
    check_val("slot", 32'(slot), 32'(e[EW-1:3*N]));
    check_val("db",   32'(db),   32'(e[3*N-1:2*N]));
    check_val("rise", 32'(rise), 32'(e[2*N-1:N]));
    check_val("fall", 32'(fall), 32'(e[N-1:0]));
    check_val("one_strobe", 32'($countones(rise | fall) <= 1), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin rise_cnt[i]++; rise_cyc[i] = cyc; end
      if (fall[i]) begin fall_cnt[i]++; fall_cyc[i] = cyc; end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; rise_cyc[i] = -1; fall_cyc[i] = -1;
    end
  endtask

  // Called at a negedge; asserting reset clears the DUT at once.
  task automatic drive_reset(input logic v);
    reset = v;
    if (!v) model_clear();
  endtask

  // Ticks until db[ch] equals v, returning elapsed cycles (limit if never).
  task automatic wait_db(input int ch, input logic v, input int limit, output int lat);
    int t0;
    t0 = cyc;
    lat = limit;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (db[ch] === v) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  // Aligns so that new switch levels are first sampled in channel 0's slot.
  task automatic align_to_window();
    for (int k = 0; k < TD + 1; k++) begin
      if (slot == SW'(TD - 2)) break;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int idx;
    int seq_v[5];
    int seq_l[5];

    model_clear();
    clear_counts();

    // 1: reset for 3 cycles, release with sw = 0, idle for 100 cycles
    drive_reset(1'b0);
    ticks(3);
    check_val("reset_slot", 32'(slot), 32'd0);
    check_val("reset_db", 32'(db), 32'd0);
    drive_reset(1'b1);
    ticks(100);
    check_val("idle_db", 32'(db), 32'd0);
    check_val("idle_strobes", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]
                                  + fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]), 32'd0);

    // 2: sw[0] rises and holds
    clear_counts();
    sw[0] = 1'b1;
    wait_db(0, 1'b1, 40, lat);
    check_val("t2_latency_18_26", 32'(lat >= 18 && lat <= 26), 32'd1);
    check_val("t2_rise_same_cycle", 32'(rise_cyc[0] == cyc), 32'd1);
    ticks(20);
    check_val("t2_rise_once", 32'(rise_cnt[0]), 32'd1);

    // 3: 10-cycle glitch on sw[1]
    clear_counts();
    sw[1] = 1'b1;
    ticks(10);
    sw[1] = 1'b0;
    ticks(40);
    check_val("t3_db1", 32'(db[1]), 32'd0);
    check_val("t3_strobes", 32'(rise_cnt[1] + fall_cnt[1]), 32'd0);

    // 4: bouncing sw[2] before settling high
    clear_counts();
    seq_v = '{1, 0, 1, 0, 1};
    seq_l = '{3, 4, 2, 2, 0};
    for (int k = 0; k < 4; k++) begin
      sw[2] = seq_v[k][0];
      ticks(seq_l[k]);
    end
    sw[2] = 1'b1;
    wait_db(2, 1'b1, 40, lat);
    check_val("t4_latency_le_26", 32'(lat <= 26), 32'd1);
    ticks(30);
    check_val("t4_rise_once", 32'(rise_cnt[2]), 32'd1);
    check_val("t4_db2", 32'(db[2]), 32'd1);

    // 5: all four channels rise together, then fall together
    sw = '0;
    ticks(40);
    check_val("t5_cleared", 32'(db), 32'd0);
    clear_counts();
    align_to_window();
    sw = '1;
    ticks(40);
    for (int i = 0; i < N; i++) begin
      check_val("t5_rise_once", 32'(rise_cnt[i]), 32'd1);
      if (i > 0) check_val("t5_rise_order", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd1);
    end
    align_to_window();
    sw = '0;
    ticks(40);
    for (int i = 0; i < N; i++) begin
      check_val("t5_fall_once", 32'(fall_cnt[i]), 32'd1);
      if (i > 0) check_val("t5_fall_order", 32'(fall_cyc[i] - fall_cyc[i-1]), 32'd1);
    end

    // 6: reset while channel 3 is two samples into a rise
    sw[3] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (run_len(3) == 2) break;
      tick();
    end
    check_val("t6_pending_2", 32'(run_len(3)), 32'd2);
    drive_reset(1'b0);
    #1;
    check_val("t6_async_db", 32'(db), 32'd0);
    check_val("t6_async_slot", 32'(slot), 32'd0);
    tick();
    drive_reset(1'b1);
    wait_db(3, 1'b1, 40, lat);
    check_val("t6_latency_18_26", 32'(lat >= 18 && lat <= 26), 32'd1);

    // 7: random switching with occasional glitches and resets
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(0, N - 1);
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(0, 399) == 0) begin
        drive_reset(1'b0);
        #1;
        check_val("rand_async_db", 32'(db), 32'd0);
        ticks($urandom_range(1, 3));
        drive_reset(1'b1);
      end
      tick();
    end

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
